// File: rtl/dcache_responder_if.sv
// Line-wide memory bus between the data cache and main memory.
// The cache is the master (issues requests); memory is the slave (acks, returns fills).
interface dcache_responder_if;
  logic         mem_req;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache responder with 16-bit words.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_responder #(
  parameter int LINES      = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ldSt_enable,
  input  logic [15:0] addr,
  input  logic [15:0] store_data,
  output logic [15:0] load_data,
  output logic        cache_stall,
  dcache_responder_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 16 - 4 - IDX_W;
  localparam int LINE_W = 16 * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [LINE_W-1:0]  data_arr [LINES];

  logic [2:0]         off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   req_tag;
  logic               is_ld;
  logic               is_st;
  logic               tag_match;
  logic               hit;
  logic               miss;
  logic               unused_addr_lsb;

  assign off             = addr[3:1];
  assign idx             = addr[4 +: IDX_W];
  assign req_tag         = addr[15 -: TAG_W];
  assign unused_addr_lsb = addr[0];

  assign is_ld     = (ldSt_enable == 2'b01);
  assign is_st     = (ldSt_enable == 2'b10);
  assign tag_match = valid[idx] && (tag_arr[idx] == req_tag);
  assign hit       = (is_ld || is_st) && tag_match && (state == IDLE);
  assign miss      = (is_ld || is_st) && !tag_match && (state == IDLE);

  assign load_data   = (hit && is_ld) ? data_arr[idx][{off, 4'b0000} +: 16] : 16'h0000;
  assign cache_stall = (state != IDLE) || miss;

  // Line storage and tags carry no reset; only valid/dirty qualify them.
  always_ff @(posedge clk) begin
    if (hit && is_st)
      data_arr[idx][{off, 4'b0000} +: 16] <= store_data;
    if ((state == FILL) && mem.mem_ack) begin
      data_arr[idx] <= mem.mem_rdata;
      tag_arr[idx]  <= req_tag;
    end
  end

  // Miss FSM; the request is held upstream, so idx/req_tag stay valid throughout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            mem.mem_req <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              state         <= WB;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= {tag_arr[idx], idx, 4'b0000};
              mem.mem_wdata <= data_arr[idx];
            end else begin
              state        <= FILL;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= {req_tag, idx, 4'b0000};
            end
          end else if (hit && is_st) begin
            dirty[idx] <= 1'b1;
          end
        end
        WB: begin
          if (mem.mem_ack) begin
            state        <= FILL;
            dirty[idx]   <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= {req_tag, idx, 4'b0000};
          end
        end
        FILL: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            valid[idx]  <= 1'b1;
            dirty[idx]  <= 1'b0;
            mem.mem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= sat_inc(hit_count);
      if (miss) miss_count <= sat_inc(miss_count);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: fills, store hits, writeback, delayed acks,
// reset during a miss, write-allocate store miss and the 11 encoding.
module tb_dcache_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ldSt_enable;
  logic [15:0] addr;
  logic [15:0] store_data;
  logic [15:0] load_data;
  logic        cache_stall;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] hits_before;
  logic [15:0] misses_before;
`endif

  int total = 0;
  int bad   = 0;

  logic [127:0] line1, line2, line3, line4, wb_exp;

  dcache_responder_if mif ();

  dcache_responder #(.LINES(4), .LINE_WORDS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ldSt_enable (ldSt_enable),
    .addr        (addr),
    .store_data  (store_data),
    .load_data   (load_data),
    .cache_stall (cache_stall),
    .mem         (mif.master)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_line(input logic [15:0] w0, input logic [15:0] base);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[16*w +: 16] = base + 16'(w);
    l[15:0] = w0;
    return l;
  endfunction

  initial begin
    line1 = mk_line(16'hBEEF, 16'hA000);
    line2 = mk_line(16'h5555, 16'h5000);
    line3 = mk_line(16'h7777, 16'h7000);
    line4 = mk_line(16'h3000, 16'h3000);
    wb_exp = line1;
    wb_exp[31:16] = 16'h1234;

    reset = 1'b1; ldSt_enable = 2'b00; addr = '0; store_data = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_req",   mif.mem_req,   0);
    check("rst_we",    mif.mem_we,    0);
    check("rst_addr",  mif.mem_addr,  0);
    check("rst_wdata", mif.mem_wdata, 0);
    check("rst_stall", cache_stall,   0);
    check("rst_ld",    load_data,     0);

    // Cold load miss, ack in the first FILL cycle
    ldSt_enable = 2'b01; addr = 16'h0040; #1;
    check("t1_stall_miss", cache_stall, 1);
    check("t1_req_idle",   mif.mem_req, 0);
    tick();
    check("t1_fill_req",  mif.mem_req,  1);
    check("t1_fill_we",   mif.mem_we,   0);
    check("t1_fill_addr", mif.mem_addr, 16'h0040);
    check("t1_fill_stall", cache_stall, 1);
    mif.mem_ack = 1'b1; mif.mem_rdata = line1;
    tick();
    mif.mem_ack = 1'b0; #1;
    check("t1_ld",      load_data,   16'hBEEF);
    check("t1_stall",   cache_stall, 0);
    check("t1_req_off", mif.mem_req, 0);
    addr = 16'h0042; #1;
    check("t1_ld_w1",   load_data,   16'hA001);

    // Store hit then load back
    ldSt_enable = 2'b10; addr = 16'h0042; store_data = 16'h1234; #1;
    check("t2_st_stall", cache_stall, 0);
    check("t2_st_ld0",   load_data,   0);
    tick();
    ldSt_enable = 2'b01; #1;
    check("t2_ld",    load_data,   16'h1234);
    check("t2_stall", cache_stall, 0);

    // Conflict miss on a dirty line: writeback held 10 cycles, then fill
    addr = 16'h0440; #1;
    check("t3_stall_miss", cache_stall, 1);
    tick();
    check("t3_wb_req",   mif.mem_req,   1);
    check("t3_wb_we",    mif.mem_we,    1);
    check("t3_wb_addr",  mif.mem_addr,  16'h0040);
    check("t3_wb_data",  mif.mem_wdata, wb_exp);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_stall", cache_stall,  1);
      check("t3_hold_we",    mif.mem_we,   1);
      check("t3_hold_addr",  mif.mem_addr, 16'h0040);
    end
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0; #1;
    check("t3_fill_req",   mif.mem_req,  1);
    check("t3_fill_we",    mif.mem_we,   0);
    check("t3_fill_addr",  mif.mem_addr, 16'h0440);
    check("t3_fill_stall", cache_stall,  1);
    mif.mem_ack = 1'b1; mif.mem_rdata = line2;
    tick();
    mif.mem_ack = 1'b0; #1;
    check("t3_ld",    load_data,   16'h5555);
    check("t3_stall", cache_stall, 0);

    // Reset while a fill is outstanding
    addr = 16'h0040; #1;
    check("t4_stall_miss", cache_stall, 1);
    tick();
    check("t4_fill_we",   mif.mem_we,   0);
    check("t4_fill_addr", mif.mem_addr, 16'h0040);
    tick();
    reset = 1'b1; ldSt_enable = 2'b00;
    tick();
    reset = 1'b0; #1;
    check("t4_rst_req",   mif.mem_req,  0);
    check("t4_rst_addr",  mif.mem_addr, 0);
    check("t4_rst_stall", cache_stall,  0);
    ldSt_enable = 2'b01; addr = 16'h0440; #1;
    check("t4_invalid_miss", cache_stall, 1);
    addr = 16'h0040; #1;
    check("t4_reload_miss", cache_stall, 1);
    tick();
    check("t4_refill_req", mif.mem_req, 1);
    check("t4_refill_we",  mif.mem_we,  0);
    mif.mem_ack = 1'b1; mif.mem_rdata = line3;
    tick();
    mif.mem_ack = 1'b0; #1;
    check("t4_ld", load_data, 16'h7777);

    // Store miss allocates the line, then the held store hits
    ldSt_enable = 2'b10; addr = 16'h00C6; store_data = 16'hCAFE; #1;
    check("t5_st_miss", cache_stall, 1);
    tick();
    check("t5_fill_we",   mif.mem_we,   0);
    check("t5_fill_addr", mif.mem_addr, 16'h00C0);
    mif.mem_ack = 1'b1; mif.mem_rdata = line4;
    tick();
    mif.mem_ack = 1'b0; #1;
    check("t5_st_hit", cache_stall, 0);
    tick();
    ldSt_enable = 2'b01; #1;
    check("t5_ld",    load_data, 16'hCAFE);
    addr = 16'h00C4; #1;
    check("t5_ld_w2", load_data, 16'h3002);

    // Stray ack while idle is ignored
    ldSt_enable = 2'b00; mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0; #1;
    check("t5_stray_req",   mif.mem_req, 0);
    check("t5_stray_stall", cache_stall, 0);

    // 11 encoding behaves as idle
`ifdef DCACHE_STATS_EN
    hits_before = hit_count; misses_before = miss_count;
`endif
    ldSt_enable = 2'b11; addr = 16'h0440; #1;
    check("t6_stall", cache_stall, 0);
    check("t6_ld",    load_data,   0);
    tick();
    check("t6_req",   mif.mem_req, 0);
    check("t6_stall2", cache_stall, 0);
`ifdef DCACHE_STATS_EN
    check("t6_hits",   hit_count,  hits_before);
    check("t6_misses", miss_count, misses_before);
`endif
    ldSt_enable = 2'b01; addr = 16'h00C6; #1;
    check("t6_still_hit", load_data, 16'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
